fifo_rd_7seg: RTL
=================

# fifo_rd_7seg

FIFO read-side consumer for the Galois-LFSR data path. It pops one byte at a time from the FIFO the generator fills, holds the byte on two active-low 7-segment digits for a fixed dwell, and optionally checks that consecutive bytes follow the same Galois sequence the generator produces. It sits between the FIFO read port and the board HEX displays.

## Interface
- `POLY`, 8'hB8: Galois feedback mask; must equal the generator's mask.
- `DWELL`, 50_000_000: display hold time per byte, in CLK cycles; minimum 1.
- `CLK`  in  1  system clock, all logic on rising edge.
- `RSTn`  in  1  asynchronous active-low reset.
- `ENrd`  in  1  read enable; low stops new reads.
- `empty`  in  1  FIFO empty flag.
- `q`  in  [8:1]  FIFO read data, valid the cycle after `rdreq`.
- `rdreq`  out  1  FIFO read request, one-cycle pulse.
- `HEX0`  out  [7:1]  low nibble of the held byte; active-low, bit 1 = seg a … bit 7 = seg g.
- `HEX1`  out  [7:1]  high nibble of the held byte; same encoding.
- `err`  out  1  sticky sequence-mismatch flag.
- `errcnt`  out  [8:1]  saturating mismatch count.
- `rdcnt`  out  [8:1]  bytes consumed since reset, wraps 255→0.

## Operation
- FSM states:
  - IDLE: `rdreq`=0. Go to RD when `ENrd`=1 and `empty`=0.
  - RD: `rdreq`=1 for exactly one cycle, then go to LAT.
  - LAT: capture `q` into `dreg`, increment `rdcnt`, run the check, load dwell counter with DWELL-1, then go to HOLD.
  - HOLD: count down; at 0 go to IDLE.
- `ENrd` is sampled only in IDLE. Deasserting it mid-read completes RD/LAT/HOLD normally.
- `empty` is sampled only in IDLE. This block is the sole consumer, so `empty` cannot rise between RD and LAT.
- `HEX0`/`HEX1` are a combinational hex-to-7-seg decode of `dreg[4:1]` / `dreg[8:5]` covering 0–F.
- Encodings, active-low {g..a}: 0=1000000, 1=1111001, A=0001000, B=0000011, 8=0000000, 5=0010010, C=1000110.
- Galois step: `nxt = d[1] ? (d>>1) ^ POLY : d>>1`.
- Checker:
  - The first byte after reset only seeds `prev`.
  - Each later byte is compared to the Galois step of `prev`.
  - On mismatch: `err` is set (sticky until reset) and `errcnt` increments, saturating at 8'hFF.
  - `prev` always updates to the received byte, so a single corrupt byte produces at most two mismatches.

## Timing
- Reset values:
  - `rdreq`=0, `dreg`=8'h00, so `HEX0`=`HEX1`=1000000.
  - `err`=0, `errcnt`=0, `rdcnt`=0.
  - FSM in IDLE, seed flag set.
- Read latency:
  - `rdreq` goes high on the edge after IDLE sees `ENrd`&&!`empty`.
  - `q` is sampled on the next edge.
  - HEX outputs change on the edge after that.
- Byte period is DWELL+3 cycles: IDLE, RD, LAT, then DWELL-1…0 in HOLD.
- If `ENrd` and `!empty` hold continuously, reads repeat back-to-back at that period.
- `err`, `errcnt` and `rdcnt` update on the same edge as `dreg`.
- Asserting `RSTn` at any point, including while `rdreq`=1, returns every register to its reset value immediately. The in-flight FIFO word is lost.

## Configuration
- `GALOIS_CHECK_EN` defined: checker, `prev`, seed flag and error logic are compiled in as described above.
- `GALOIS_CHECK_EN` undefined: checker logic is removed. `err` is tied 0 and `errcnt` is tied 8'h00. FSM, display and `rdcnt` are unchanged.

## Test plan
- Reset, then FIFO model holds 01, B8, 5C, 2E, 17, B3; `ENrd`=1, DWELL=4 → six `rdreq` pulses 7 cycles apart; HEX pairs show 0/1, B/8, 5/C, 2/E, 1/7, B/3; `err`=0; `rdcnt`=6.
- Same stream with 5C replaced by 5D → `err` rises at the LAT of 5D; `errcnt`=2 after 2E is read; `err` stays 1.
- `empty`=1 with `ENrd`=1 for 20 cycles → `rdreq` never asserts; HEX unchanged. `empty` falls → `rdreq` pulses on the next edge.
- `ENrd` dropped during RD → the byte is still latched and displayed; no further `rdreq` until `ENrd`=1.
- `RSTn` pulsed low while `rdreq`=1 → all outputs immediately at reset values. The next byte read is treated as the seed: no error even if it does not follow the previous byte.
- 256 reads of a valid sequence → `rdcnt` wraps to 0; `errcnt` saturation checked with 260 forced mismatches → stays at FF.

Source files
------------

// File: rtl/fifo_rd_7seg.sv
// fifo_rd_7seg: pops bytes from a FIFO and holds each one on two active-low 7-seg digits for DWELL cycles.
// Define GALOIS_CHECK_EN to verify that consecutive bytes follow the POLY Galois LFSR sequence.
module fifo_rd_7seg #(
    parameter logic [8:1] POLY  = 8'hB8,
    parameter int         DWELL = 50_000_000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       ENrd,
    input  logic       empty,
    input  logic [8:1] q,
    output logic       rdreq,
    output logic [7:1] HEX0,
    output logic [7:1] HEX1,
    output logic       err,
    output logic [8:1] errcnt,
    output logic [8:1] rdcnt
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, RD, LAT, HOLD} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] dwell;
    logic [8:1]    dreg;

    always_comb begin
        state_nx = state;
        rdreq    = 1'b0;
        case (state)
            IDLE:    state_nx = (ENrd && !empty) ? RD : IDLE;
            RD: begin
                rdreq    = 1'b1;
                state_nx = LAT;
            end
            LAT:     state_nx = HOLD;
            HOLD:    state_nx = (dwell == '0) ? IDLE : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // q is valid during LAT, one cycle after the rdreq pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            dwell <= '0;
            dreg  <= '0;
            rdcnt <= '0;
        end else begin
            state <= state_nx;
            if (state == LAT) begin
                dreg  <= q;
                rdcnt <= rdcnt + 8'd1;
                dwell <= CW'(DWELL - 1);
            end else if (state == HOLD && dwell != '0) begin
                dwell <= dwell - CW'(1);
            end
        end
    end

    function automatic logic [7:1] seg(input logic [3:0] n);
        case (n)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    assign HEX0 = seg(dreg[4:1]);
    assign HEX1 = seg(dreg[8:5]);

`ifdef GALOIS_CHECK_EN
    logic [8:1] prev;
    logic [8:1] nxt;
    logic       seed;

    assign nxt = prev[1] ? ((prev >> 1) ^ POLY) : (prev >> 1);

    // prev always follows the received byte so one corrupt byte costs at most two mismatches
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            prev   <= '0;
            seed   <= 1'b1;
            err    <= 1'b0;
            errcnt <= '0;
        end else if (state == LAT) begin
            prev <= q;
            seed <= 1'b0;
            if (!seed && q != nxt) begin
                err <= 1'b1;
                if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
            end
        end
    end
`else
    assign err    = 1'b0;
    assign errcnt = 8'h00;
`endif
endmodule
